core_id_scoreboard: RTL



---
 rtl/core_id_scoreboard_pkg.sv | 29 ++
 rtl/core_id_scoreboard.sv | 129 ++++++++++++
 2 files changed

// File: rtl/core_id_scoreboard_pkg.sv
// ----------------------------------------------------------------------------
// core_id_scoreboard_pkg
// Purpose : shared core-wide defines (register-index width, XLEN, default
//           long-op outstanding limit) plus the localparams and types used by
//           the issue scoreboard.
// Ports   : none (package).
// ----------------------------------------------------------------------------
`ifndef CORE_DEFINES_SV
`define CORE_DEFINES_SV
`define CORE_XLEN         32
`define CORE_RFIDX_WIDTH  5
`define CORE_LONG_OSTD    2
`endif

package core_id_scoreboard_pkg;

  localparam int RFIDX_W       = `CORE_RFIDX_WIDTH;
  localparam int XLEN          = `CORE_XLEN;
  localparam int LONG_OSTD_DEF = `CORE_LONG_OSTD;

  // One cycle's worth of scoreboard activity.
  typedef struct packed {
    logic set;   // issuing long op claims rd
    logic clr;   // long-op writeback releases wb_idx
    logic inc;   // long op issued
    logic dec;   // long op retired
  } sb_upd_t;

endpackage

// File: rtl/core_id_scoreboard.sv
// ----------------------------------------------------------------------------
// core_id_scoreboard
// Purpose : issue controller between decode and execute. Tracks destination
//           registers of in-flight long-latency ops (loads, CSR reads) and
//           stalls any decoded instruction whose sources or rd are pending.
//           Also throttles long-op issue at LONG_OSTD outstanding and drains
//           the decode slot on flush. Hazards use registered state only.
// Ports   :
//   clk, rst                   clock, synchronous active-high reset
//   i_dec_valid / o_dec_ready  decode handshake
//   i_rs1_ren, i_rs2_ren       source read enables
//   i_rs1_idx, i_rs2_idx       source indices
//   i_rd_idx, i_rd_wen         destination index / write enable
//   i_long                     long-latency op
//   o_iss_valid / i_iss_ready  issue handshake to execute
//   i_wb_valid, i_wb_idx       long-op writeback
//   i_flush                    kill instruction in decode
//   o_stall                    decode held by a hazard
//   o_busy                     long ops outstanding
//   o_pending                  scoreboard bits (bit 0 always 0)
//   o_err                      sticky protocol error
// ----------------------------------------------------------------------------
module core_id_scoreboard
  import core_id_scoreboard_pkg::*;
#(
  parameter int RF_NUM    = 32,
  parameter int LONG_OSTD = LONG_OSTD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_dec_valid,
  output logic               o_dec_ready,
  input  logic               i_rs1_ren,
  input  logic               i_rs2_ren,
  input  logic [RFIDX_W-1:0] i_rs1_idx,
  input  logic [RFIDX_W-1:0] i_rs2_idx,
  input  logic [RFIDX_W-1:0] i_rd_idx,
  input  logic               i_rd_wen,
  input  logic               i_long,
  output logic               o_iss_valid,
  input  logic               i_iss_ready,
  input  logic               i_wb_valid,
  input  logic [RFIDX_W-1:0] i_wb_idx,
  input  logic               i_flush,
  output logic               o_stall,
  output logic               o_busy,
  output logic [RF_NUM-1:0]  o_pending,
  output logic               o_err
);

  localparam int CW = $clog2(LONG_OSTD + 1);

  logic [RF_NUM-1:0] r_pend;
  logic [CW-1:0]     r_cnt;
  logic              r_err;

  logic [RF_NUM-1:0] w_pend_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_err_nxt;
  logic              w_hazard;
  logic              w_full;
  logic              w_fire;
  sb_upd_t           w_upd;

  // x0 and out-of-range indices never hit.
  function automatic logic pend_hit(input logic [RF_NUM-1:0] p,
                                    input logic [RFIDX_W-1:0] idx);
    logic hit;
    hit = 1'b0;
    if (idx != '0 && int'(idx) < RF_NUM) hit = p[idx];
    return hit;
  endfunction

  assign w_full   = (r_cnt == CW'(LONG_OSTD));
  assign w_hazard = (i_rs1_ren & pend_hit(r_pend, i_rs1_idx)) |
                    (i_rs2_ren & pend_hit(r_pend, i_rs2_idx)) |
                    (i_rd_wen  & pend_hit(r_pend, i_rd_idx))  |
                    (i_long    & w_full);

  assign o_iss_valid = i_dec_valid & ~w_hazard & ~i_flush;
  assign o_dec_ready = i_flush | (i_iss_ready & ~w_hazard);
  assign o_stall     = i_dec_valid & w_hazard & ~i_flush;
  assign w_fire      = o_iss_valid & i_iss_ready;

  assign w_upd.set = w_fire & i_long & i_rd_wen & (i_rd_idx != '0);
  assign w_upd.clr = i_wb_valid & (i_wb_idx != '0);
  assign w_upd.inc = w_fire & i_long;
  assign w_upd.dec = i_wb_valid;

  always_comb begin
    w_pend_nxt = r_pend;
    w_cnt_nxt  = r_cnt;
    w_err_nxt  = r_err;

    // Clear first so a same-index set overrides it.
    if (w_upd.clr && int'(i_wb_idx) < RF_NUM) w_pend_nxt[i_wb_idx] = 1'b0;
    if (w_upd.set && int'(i_rd_idx) < RF_NUM) w_pend_nxt[i_rd_idx] = 1'b1;
    w_pend_nxt[0] = 1'b0;

    if (w_upd.set && w_upd.clr && i_rd_idx == i_wb_idx) w_err_nxt = 1'b1;

    unique case ({w_upd.inc, w_upd.dec})
      2'b10: w_cnt_nxt = r_cnt + CW'(1);
      2'b01: begin
        // Writeback with nothing outstanding: hold at 0, flag it.
        if (r_cnt == '0) w_err_nxt = 1'b1;
        else             w_cnt_nxt = r_cnt - CW'(1);
      end
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= w_cnt_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign o_pending = r_pend;
  assign o_busy    = (r_cnt != '0);
  assign o_err     = r_err;

endmodule
